// File: rtl/snn_pkg.sv
// Shared types, network-wide defaults and helpers for the spiking network.
package snn_pkg;

    // Neuron control states
    typedef enum logic [0:0] {
        INTEGRATE = 1'b0,
        REFRACT   = 1'b1
    } lif_state_t;

    // Defaults shared by every stage of the network
    localparam int DEF_THRESHOLD   = 100;
    localparam int DEF_LEAK_SHIFT  = 3;
    localparam int DEF_REFRACTORY  = 2;
    localparam int DEF_WINDOW_SIZE = 5;

    // Working width for the pre-clamp potential; wide enough for any
    // potential plus weighted sum used in this network.
    localparam int CLAMP_IN_WIDTH  = 48;

    // Saturate a signed value into the unsigned range [0, 2^pot_width-1].
    function automatic logic [CLAMP_IN_WIDTH-1:0] sat_clamp(
        input logic signed [CLAMP_IN_WIDTH-1:0] x,
        input int unsigned                      pot_width
    );
        logic signed [CLAMP_IN_WIDTH-1:0] max_v;
        logic [CLAMP_IN_WIDTH-1:0]        res;
        max_v = (48'sd1 <<< pot_width) - 48'sd1;
        if (x < 48'sd0) begin
            res = 48'd0;
        end else if (x > max_v) begin
            res = max_v;
        end else begin
            res = x;
        end
        return res;
    endfunction

endpackage

// File: rtl/weighted_spike_adder.sv
// Combinational masked signed sum: adds weight i whenever spike bit i is set.
module weighted_spike_adder
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS   = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int SUM_WIDTH    = 27
) (
    input  logic [NUM_INPUTS-1:0]              spike_mask,
    input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weights,
    output logic signed [SUM_WIDTH-1:0]        sum
);

    // Accumulate sign-extended weights of the active channels
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (spike_mask[i]) begin
                sum = sum + SUM_WIDTH'(signed'(weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
            end else begin
                sum = sum;
            end
        end
    end

endmodule

// File: rtl/lif_neuron.sv
// Integer leaky integrate-and-fire neuron with refractory period and a
// per-frame output spike counter aligned to the spike generators' window.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS   = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int POT_WIDTH    = 16,
    parameter int THRESHOLD    = DEF_THRESHOLD,
    parameter int LEAK_SHIFT   = DEF_LEAK_SHIFT,
    parameter int REFRACTORY   = DEF_REFRACTORY,
    parameter int WINDOW_SIZE  = DEF_WINDOW_SIZE
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [NUM_INPUTS-1:0]                 spike_in,
    input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0]    weights,
    output logic                                  spike_out,
    output logic [POT_WIDTH-1:0]                  membrane_potential,
    output logic                                  window_done,
    output logic [$clog2(WINDOW_SIZE+1)-1:0]      spike_count
);

    localparam int SUM_WIDTH = POT_WIDTH + WEIGHT_WIDTH + $clog2(NUM_INPUTS) + 1;
    localparam int CNT_WIDTH = $clog2(WINDOW_SIZE + 1);
    localparam int REF_WIDTH = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    localparam logic [POT_WIDTH-1:0] THR_V = POT_WIDTH'(THRESHOLD);

    // State
    lif_state_t                  state_r;
    logic [POT_WIDTH-1:0]        v_r;
    logic [REF_WIDTH-1:0]        ref_cnt_r;
    logic [CNT_WIDTH-1:0]        win_cnt_r;
    logic [CNT_WIDTH-1:0]        tally_r;
    logic                        spike_out_r;
    logic                        window_done_r;
    logic [CNT_WIDTH-1:0]        spike_count_r;

    // Datapath
    logic signed [SUM_WIDTH-1:0]      sum_s;
    logic [POT_WIDTH-1:0]             leaked_s;
    logic signed [CLAMP_IN_WIDTH-1:0] pre_s;
    logic [CLAMP_IN_WIDTH-1:0]        clamp_wide_s;
    logic [POT_WIDTH-1:0]             v_next_s;
    logic                             fire_s;
    logic                             last_step_s;
    logic [CNT_WIDTH-1:0]             tally_next_s;

    weighted_spike_adder #(
        .NUM_INPUTS   (NUM_INPUTS),
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .SUM_WIDTH    (SUM_WIDTH)
    ) u_adder (
        .spike_mask (spike_in),
        .weights    (weights),
        .sum        (sum_s)
    );

    // Leak, integrate, saturate and decide whether this step fires
    always_comb begin
        leaked_s     = v_r - (v_r >> LEAK_SHIFT);
        pre_s        = signed'(CLAMP_IN_WIDTH'(leaked_s)) + CLAMP_IN_WIDTH'(sum_s);
        clamp_wide_s = sat_clamp(pre_s, POT_WIDTH);
        v_next_s     = POT_WIDTH'(clamp_wide_s);
        if (state_r == INTEGRATE) begin
            fire_s = (v_next_s >= THR_V);
        end else begin
            fire_s = 1'b0;
        end
        last_step_s  = (win_cnt_r == CNT_WIDTH'(WINDOW_SIZE - 1));
        tally_next_s = tally_r + CNT_WIDTH'(fire_s);
    end

    // Neuron FSM, window counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= INTEGRATE;
            v_r           <= '0;
            ref_cnt_r     <= '0;
            win_cnt_r     <= '0;
            tally_r       <= '0;
            spike_out_r   <= 1'b0;
            window_done_r <= 1'b0;
            spike_count_r <= '0;
        end else if (in_valid) begin
            spike_out_r <= fire_s;
            if (last_step_s) begin
                // Frame boundary: publish the count and start the next frame clean
                window_done_r <= 1'b1;
                spike_count_r <= tally_next_s;
                tally_r       <= '0;
                win_cnt_r     <= '0;
                v_r           <= '0;
                ref_cnt_r     <= '0;
                state_r       <= INTEGRATE;
            end else begin
                window_done_r <= 1'b0;
                tally_r       <= tally_next_s;
                win_cnt_r     <= win_cnt_r + CNT_WIDTH'(1);
                case (state_r)
                    INTEGRATE: begin
                        if (fire_s) begin
                            v_r <= '0;
                            if (REFRACTORY > 0) begin
                                state_r   <= REFRACT;
                                ref_cnt_r <= REF_WIDTH'(REFRACTORY);
                            end else begin
                                state_r   <= INTEGRATE;
                                ref_cnt_r <= '0;
                            end
                        end else begin
                            v_r <= v_next_s;
                        end
                    end
                    REFRACT: begin
                        v_r <= '0;
                        if (ref_cnt_r <= REF_WIDTH'(1)) begin
                            ref_cnt_r <= '0;
                            state_r   <= INTEGRATE;
                        end else begin
                            ref_cnt_r <= ref_cnt_r - REF_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_r   <= INTEGRATE;
                        v_r       <= '0;
                        ref_cnt_r <= '0;
                    end
                endcase
            end
        end else begin
            // Idle cycle: everything holds, pulses drop
            spike_out_r   <= 1'b0;
            window_done_r <= 1'b0;
        end
    end

    assign spike_out          = spike_out_r;
    assign membrane_potential = v_r;
    assign window_done        = window_done_r;
    assign spike_count        = spike_count_r;

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: directed frames with hand-computed
// values plus randomized traffic checked against a behavioural model.
module tb_lif_neuron;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  spike_in;
    logic [31:0] weights;

    // Instance 0: default refractory of 2; instance 1: no refractory
    logic        so0, so1;
    logic [15:0] pot0, pot1;
    logic        wd0, wd1;
    logic [2:0]  cnt0, cnt1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    lif_neuron dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .spike_in(spike_in),
        .weights(weights), .spike_out(so0), .membrane_potential(pot0),
        .window_done(wd0), .spike_count(cnt0)
    );

    lif_neuron #(.REFRACTORY(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .spike_in(spike_in),
        .weights(weights), .spike_out(so1), .membrane_potential(pot1),
        .window_done(wd1), .spike_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: potential, remaining refractory steps, steps seen in the
    // current frame, spikes in the current frame, and expected outputs.
    int m_v[2], m_ref[2], m_step[2], m_tally[2];
    int e_spike[2], e_v[2], e_done[2], e_cnt[2];

    function automatic int refr_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic model_step(input int k);
        int sum, nv, fire;
        logic [7:0] w;
        if (!in_valid) begin
            e_spike[k] = 0;
            e_done[k]  = 0;
        end else begin
            m_step[k]++;
            fire = 0;
            if (m_ref[k] > 0) begin
                m_ref[k]--;
                m_v[k] = 0;
            end else begin
                sum = 0;
                for (int i = 0; i < 4; i++) begin
                    w = weights[i*8 +: 8];
                    if (spike_in[i]) sum += int'($signed(w));
                end
                nv = m_v[k] - m_v[k] / 8 + sum;
                if (nv < 0) nv = 0;
                if (nv > 65535) nv = 65535;
                if (nv >= 100) begin
                    fire     = 1;
                    m_v[k]   = 0;
                    m_ref[k] = refr_of(k);
                end else begin
                    m_v[k] = nv;
                end
            end
            m_tally[k] += fire;
            e_spike[k] = fire;
            if (m_step[k] == 5) begin
                e_done[k]  = 1;
                e_cnt[k]   = m_tally[k];
                m_tally[k] = 0;
                m_step[k]  = 0;
                m_v[k]     = 0;
                m_ref[k]   = 0;
            end else begin
                e_done[k] = 0;
            end
            e_v[k] = m_v[k];
        end
    endtask

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_v[k] = 0; m_ref[k] = 0; m_step[k] = 0; m_tally[k] = 0;
                e_spike[k] = 0; e_v[k] = 0; e_done[k] = 0; e_cnt[k] = 0;
            end else begin
                model_step(k);
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("u0.spike_out", 32'(so0),  32'(e_spike[0]));
            check("u0.potential", 32'(pot0), 32'(e_v[0]));
            check("u0.window_done", 32'(wd0), 32'(e_done[0]));
            check("u0.spike_count", 32'(cnt0), 32'(e_cnt[0]));
            check("u1.spike_out", 32'(so1),  32'(e_spike[1]));
            check("u1.potential", 32'(pot1), 32'(e_v[1]));
            check("u1.window_done", 32'(wd1), 32'(e_done[1]));
            check("u1.spike_count", 32'(cnt1), 32'(e_cnt[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present one cycle of inputs; returns #1 after the edge that samples them.
    task automatic apply(input logic v, input logic [3:0] s, input logic [31:0] w);
        in_valid = v;
        spike_in = s;
        weights  = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int w;
        logic [31:0] rw;
        rst = 1'b0; in_valid = 1'b0; spike_in = 4'b0000; weights = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("reset.pot0", 32'(pot0), 32'd0);
        check("reset.cnt0", 32'(cnt0), 32'd0);
        rst = 1'b1;

        // All weights 30, all channels spiking
        apply(1'b1, 4'b1111, 32'h1E1E1E1E);
        check("t1.step1.spike", 32'(so0), 32'd1);
        apply(1'b1, 4'b1111, 32'h1E1E1E1E);
        apply(1'b1, 4'b1111, 32'h1E1E1E1E);
        apply(1'b1, 4'b1111, 32'h1E1E1E1E);
        check("t1.step4.spike", 32'(so0), 32'd1);
        apply(1'b1, 4'b1111, 32'h1E1E1E1E);
        check("t1.done", 32'(wd0), 32'd1);
        check("t1.count", 32'(cnt0), 32'd2);
        check("t1.pot", 32'(pot0), 32'd0);
        check("t1.count_norefr", 32'(cnt1), 32'd5);

        // Channel 0 only, weight 40
        do_reset();
        apply(1'b1, 4'b0001, 32'h00000028);
        check("t2.pot40", 32'(pot0), 32'd40);
        apply(1'b1, 4'b0001, 32'h00000028);
        check("t2.pot75", 32'(pot0), 32'd75);
        apply(1'b1, 4'b0001, 32'h00000028);
        check("t2.fire", 32'(so0), 32'd1);
        check("t2.pot0", 32'(pot0), 32'd0);

        // Negative weight must clamp at zero
        do_reset();
        apply(1'b1, 4'b0001, 32'h000000CE);
        check("t3.clamp", 32'(pot0), 32'd0);
        apply(1'b1, 4'b0001, 32'h000000CE);
        check("t3.clamp2", 32'(pot0), 32'd0);

        // Fire on step 2, idle cycles, refractory consumes next 2 valid steps
        do_reset();
        apply(1'b1, 4'b0001, 32'h0000003C);
        apply(1'b1, 4'b0001, 32'h0000003C);
        check("t4.fire", 32'(so0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 4'b0001, 32'h0000003C);
            check("t4.idle.spike", 32'(so0), 32'd0);
        end
        apply(1'b1, 4'b0001, 32'h0000003C);
        check("t4.refr1.pot", 32'(pot0), 32'd0);
        apply(1'b1, 4'b0001, 32'h0000003C);
        check("t4.refr2.pot", 32'(pot0), 32'd0);
        apply(1'b1, 4'b0001, 32'h0000003C);
        check("t4.done", 32'(wd0), 32'd1);
        check("t4.count", 32'(cnt0), 32'd1);
        apply(1'b1, 4'b0001, 32'h0000003C);
        check("t4.integrating", 32'(pot0), 32'd60);

        // Reset mid-window with v=60
        do_reset();
        apply(1'b1, 4'b0001, 32'h00000020);
        apply(1'b1, 4'b0001, 32'h00000020);
        check("t5.pot60", 32'(pot0), 32'd60);
        in_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("t5.rst.pot", 32'(pot0), 32'd0);
        check("t5.rst.cnt", 32'(cnt0), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) apply(1'b1, 4'b0000, 32'h0);
        check("t5.no_early_done", 32'(wd0), 32'd0);
        apply(1'b1, 4'b0000, 32'h0);
        check("t5.done", 32'(wd0), 32'd1);

        // Max weights everywhere: no-refractory instance fires every step
        do_reset();
        for (int i = 0; i < 5; i++) apply(1'b1, 4'b1111, 32'h7F7F7F7F);
        check("t6.count_norefr", 32'(cnt1), 32'd5);
        check("t6.count_refr", 32'(cnt0), 32'd2);
        check("t6.both_pulse", 32'({so1, wd1}), 32'd3);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < 4; i++) begin
                    w = int'($urandom_range(0, 187)) - 60;
                    rw[i*8 +: 8] = 8'(w);
                end
                apply($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rw);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Integer leaky integrate-and-fire neuron, the stage directly downstream of the Poisson spike generators. It consumes one spike bit per input channel per time step and applies a signed integer weight to each. It integrates the weighted sum into a leaky membrane potential and emits an output spike on threshold crossing, followed by a refractory period. It also counts output spikes over a fixed window of time steps, matching the generators' window, so a classifier stage can read one spike count per presented pixel frame.

## Interface
- NUM_INPUTS, 4, number of input spike channels
- WEIGHT_WIDTH, 8, width of each signed two's-complement weight
- POT_WIDTH, 16, membrane potential width, unsigned, range 0..2^POT_WIDTH-1
- THRESHOLD, 100, firing threshold; fire when potential >= THRESHOLD
- LEAK_SHIFT, 3, leak is v >> LEAK_SHIFT per step
- REFRACTORY, 2, time steps ignored after a spike
- WINDOW_SIZE, 5, time steps per counting window
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  one time step is presented this cycle
- spike_in  input  NUM_INPUTS  spike bit per channel, sampled only when in_valid=1
- weights  input  NUM_INPUTS*WEIGHT_WIDTH  flat signed weights, channel i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- spike_out  output  1  registered one-cycle pulse on fire
- membrane_potential  output  POT_WIDTH  registered current potential
- window_done  output  1  one-cycle pulse when a window completes
- spike_count  output  $clog2(WINDOW_SIZE+1)  spikes in the last completed window, held until the next window_done

## Operation
- FSM has two states.
  - INTEGRATE: integrate inputs and fire on threshold.
  - REFRACT: a counter loaded with REFRACTORY; each valid step decrements it; return to INTEGRATE when it reaches 0 on a valid step.
- Valid step in INTEGRATE:
  - sum = signed sum of weights[i] for every i with spike_in[i]=1, width POT_WIDTH+WEIGHT_WIDTH+$clog2(NUM_INPUTS)+1, no overflow.
  - v_next = v - (v >> LEAK_SHIFT) + sum, clamped to [0, 2^POT_WIDTH-1].
  - If v_next >= THRESHOLD: spike_out=1, v=0, go to REFRACT (when REFRACTORY=0, stay in INTEGRATE).
  - Otherwise v=v_next.
- Valid step in REFRACT: inputs ignored, v held at 0, spike_out=0.
- Window counter counts valid steps 1..WINDOW_SIZE, regardless of state. On the WINDOW_SIZE-th valid step:
  - window_done=1.
  - spike_count = window spikes including any spike on that same step.
  - Internal spike tally, v, refractory counter and state all reset (v=0, INTEGRATE) for the next frame.
- in_valid=0: all state and outputs hold, except that spike_out and window_done drop to 0.
- Reset values: spike_out=0, membrane_potential=0, window_done=0, spike_count=0, state INTEGRATE, window counter 0, refractory counter 0.

## Timing
- Latency is 1 cycle: outputs reflect the valid step presented on the previous edge.
- in_valid may be asserted every cycle. There is no backpressure and no ready signal.
- Reset mid-window aborts the window immediately: window_done is not pulsed and the partial tally is discarded.
- A fire on the final window step gives spike_out=1 and window_done=1 in the same cycle, and the count includes that spike.

## Structure
- Shared package snn_pkg holds:
  - the lif_state_t enum (INTEGRATE, REFRACT);
  - a saturating-clamp function for the potential;
  - the default THRESHOLD, LEAK_SHIFT, REFRACTORY and WINDOW_SIZE constants used across the network.
- Sub-module weighted_spike_adder: combinational masked signed sum of NUM_INPUTS weights.
- The FSM and counters stay in lif_neuron.

## Test plan
- All weights 30, spike_in=4'b1111, in_valid=1 for 5 cycles -> spike_out on valid steps 1 and 4, window_done on step 5 with spike_count=2, membrane_potential=0 after.
- Only channel 0 spiking with weight 40 -> potential 40, then 75 (40-5+40), then fire on step 3 (75-9+40=106), membrane_potential=0.
- Weight -50 with v=0 -> membrane_potential stays 0, no underflow wrap.
- Fire on step 2, then in_valid=0 for 3 cycles -> outputs hold, spike_out low; refractory still consumes the next 2 valid steps.
- rst low at step 3 of a window with v=60 -> all outputs 0 immediately; next window needs a full 5 valid steps before window_done.
- Weights all 127, every step spiking, WINDOW_SIZE=5, REFRACTORY=0 -> spike on all 5 steps, spike_count=5 (saturated count width correct).
